// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Register scoreboard and issue controller for the ID stage. Each
// architectural register has a countdown counter of pending result latency.
// A read of a register whose counter is nonzero stalls the instruction, and a
// RUN/DRAIN/HALTED controller lets in-flight writes finish before halting.
//
// Optional feature macro: HAZARD_SCOREBOARD_WAW_EN
//   defined   : a write to a register with a pending write also stalls (WAW)
//   undefined : such a write is accepted and overwrites the pending counter
//
// Handshake: issue_valid is the request and issue_accept is the grant for the
// same cycle. The instruction moves into ID/EX exactly on cycles where
// issue_accept=1. stall=1 means the same instruction must be presented again,
// and flush withdraws the request without stalling.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int LAT_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    input  logic                         issue_we,
    input  logic [REG_ADDR_W-1:0]        issue_dst,
    input  logic [LAT_W-1:0]             issue_lat,
    input  logic [REG_ADDR_W-1:0]        src0_addr,
    input  logic [REG_ADDR_W-1:0]        src1_addr,
    input  logic                         src0_used,
    input  logic                         src1_used,
    input  logic                         flush,
    input  logic                         halt_req,
    input  logic                         resume,
    output logic                         issue_accept,
    output logic                         stall,
    output logic [(1<<REG_ADDR_W)-1:0]   busy_mask,
    output logic                         halted,
    output logic                         draining,
    output logic [1:0]                   state_dbg
);

    localparam int NREG = 1 << REG_ADDR_W;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [LAT_W-1:0] cnt [NREG];
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             hazard;
    logic             load_en;

    // A register is busy while its pending-latency counter is nonzero.
    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_mask[r] = (cnt[r] != '0);
        end
    end

    // RAW hazard from the registered counters; WAW term only when enabled.
    always_comb begin
        hazard = (src0_used && busy_mask[src0_addr]) ||
                 (src1_used && busy_mask[src1_addr]);
`ifdef HAZARD_SCOREBOARD_WAW_EN
        hazard = hazard || (issue_we && busy_mask[issue_dst]);
`else
        hazard = hazard;
`endif
    end

    // Issue decision: flush withdraws the request, otherwise stall on a hazard
    // or whenever the controller is not in RUN.
    always_comb begin
        stall        = issue_valid && !flush && (hazard || (state != ST_RUN));
        issue_accept = issue_valid && !flush && !stall;
        load_en      = issue_accept && issue_we;
    end

    // Counters: load on an accepted write (load wins), else count down to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (load_en && (issue_dst == REG_ADDR_W'(r))) begin
                    cnt[r] <= issue_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    // Controller next state: halt drains pending writes before HALTED.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (halt_req)          state_nxt = ST_DRAIN;
            ST_DRAIN:  if (busy_mask == '0)   state_nxt = ST_HALTED;
            ST_HALTED: if (resume)            state_nxt = ST_RUN;
            default:                          state_nxt = ST_RUN;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Status outputs decoded from the controller state.
    always_comb begin
        halted    = (state == ST_HALTED);
        draining  = (state == ST_DRAIN);
        state_dbg = state;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed vector table, an asynchronous
// reset during DRAIN, then randomized traffic against a ready-time model.
module tb_hazard_scoreboard;

    localparam int AW   = 4;
    localparam int LW   = 2;
    localparam int NREG = 1 << AW;

    logic            clk;
    logic            rst;
    logic            issue_valid;
    logic            issue_we;
    logic [AW-1:0]   issue_dst;
    logic [LW-1:0]   issue_lat;
    logic [AW-1:0]   src0_addr;
    logic [AW-1:0]   src1_addr;
    logic            src0_used;
    logic            src1_used;
    logic            flush;
    logic            halt_req;
    logic            resume;
    logic            issue_accept;
    logic            stall;
    logic [NREG-1:0] busy_mask;
    logic            halted;
    logic            draining;
    logic [1:0]      state_dbg;

    hazard_scoreboard #(.REG_ADDR_W(AW), .LAT_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_dst    (issue_dst),
        .issue_lat    (issue_lat),
        .src0_addr    (src0_addr),
        .src1_addr    (src1_addr),
        .src0_used    (src0_used),
        .src1_used    (src1_used),
        .flush        (flush),
        .halt_req     (halt_req),
        .resume       (resume),
        .issue_accept (issue_accept),
        .stall        (stall),
        .busy_mask    (busy_mask),
        .halted       (halted),
        .draining     (draining),
        .state_dbg    (state_dbg)
    );

    // Clock and counters
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic v, we;
        logic [AW-1:0] dst;
        logic [LW-1:0] lat;
        logic [AW-1:0] s0;
        logic u0;
        logic [AW-1:0] s1;
        logic u1;
        logic fl, hr, rs;
        logic acc, stl;
        logic [NREG-1:0] busy;
        logic hlt, drn;
    } vec_t;

    vec_t vecs[$];

    // Reference model: each register becomes free at an absolute cycle number;
    // the controller is tracked as a mode name.
    typedef enum int {M_RUN, M_DRAIN, M_HALTED} mode_t;
    longint cyc;
    longint ready_at [NREG];
    mode_t  mode;

    function automatic logic m_busy_reg(int r);
        return ready_at[r] > cyc;
    endfunction

    function automatic logic [NREG-1:0] m_busy();
        logic [NREG-1:0] m;
        m = '0;
        for (int r = 0; r < NREG; r++) m[r] = m_busy_reg(r);
        return m;
    endfunction

    function automatic logic m_stall();
        logic hz;
        hz = (src0_used && m_busy_reg(int'(src0_addr))) ||
             (src1_used && m_busy_reg(int'(src1_addr)));
`ifdef HAZARD_SCOREBOARD_WAW_EN
        hz = hz || (issue_we && m_busy_reg(int'(issue_dst)));
`endif
        return issue_valid && !flush && (hz || mode != M_RUN);
    endfunction

    function automatic logic m_accept();
        return issue_valid && !flush && !m_stall();
    endfunction

    task automatic model_reset();
        cyc  = 0;
        mode = M_RUN;
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    endtask

    // Advance the model over one clock edge using the current inputs.
    task automatic model_edge();
        logic [NREG-1:0] bm;
        bm = m_busy();
        if (m_accept() && issue_we) ready_at[int'(issue_dst)] = cyc + 1 + longint'(issue_lat);
        case (mode)
            M_RUN:    if (halt_req) mode = M_DRAIN;
            M_DRAIN:  if (bm == '0) mode = M_HALTED;
            M_HALTED: if (resume) mode = M_RUN;
            default:  mode = M_RUN;
        endcase
        cyc++;
    endtask

    // Scoreboard compare
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic v, input logic we, input int dst, input int lat,
        input int s0, input logic u0, input int s1, input logic u1,
        input logic fl, input logic hr, input logic rs,
        input logic acc, input logic stl, input logic [NREG-1:0] busy,
        input logic hlt, input logic drn);
        vec_t t;
        t.v = v; t.we = we; t.dst = AW'(dst); t.lat = LW'(lat);
        t.s0 = AW'(s0); t.u0 = u0; t.s1 = AW'(s1); t.u1 = u1;
        t.fl = fl; t.hr = hr; t.rs = rs;
        t.acc = acc; t.stl = stl; t.busy = busy; t.hlt = hlt; t.drn = drn;
        return t;
    endfunction

    function automatic vec_t idle(input logic [NREG-1:0] busy, input logic hlt, input logic drn);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, busy, hlt, drn);
    endfunction

    // Driver tasks
    task automatic drive(input vec_t t);
        issue_valid = t.v;  issue_we  = t.we; issue_dst = t.dst; issue_lat = t.lat;
        src0_addr   = t.s0; src0_used = t.u0; src1_addr = t.s1;  src1_used = t.u1;
        flush       = t.fl; halt_req  = t.hr; resume    = t.rs;
    endtask

    // One cycle: inputs already driven; compare mid-cycle, then take the edge.
    task automatic step(input string tag, input bit use_exp, input vec_t t);
        @(negedge clk);
        chk({tag, ".accept"},   32'(issue_accept), 32'(m_accept()));
        chk({tag, ".stall"},    32'(stall),        32'(m_stall()));
        chk({tag, ".busy"},     32'(busy_mask),    32'(m_busy()));
        chk({tag, ".halted"},   32'(halted),       32'(mode == M_HALTED));
        chk({tag, ".draining"}, 32'(draining),     32'(mode == M_DRAIN));
        if (use_exp) begin
            chk({tag, ".tbl_accept"},   32'(issue_accept), 32'(t.acc));
            chk({tag, ".tbl_stall"},    32'(stall),        32'(t.stl));
            chk({tag, ".tbl_busy"},     32'(busy_mask),    32'(t.busy));
            chk({tag, ".tbl_halted"},   32'(halted),       32'(t.hlt));
            chk({tag, ".tbl_draining"}, 32'(draining),     32'(t.drn));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        drive(idle('0, 0, 0));
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        chk("reset.accept",   32'(issue_accept), 32'(0));
        chk("reset.stall",    32'(stall),        32'(0));
        chk("reset.busy",     32'(busy_mask),    32'(0));
        chk("reset.halted",   32'(halted),       32'(0));
        chk("reset.draining", 32'(draining),     32'(0));
        rst = 1'b1;
    endtask

    initial begin
        vec_t t;
        model_reset();
        drive(idle('0, 0, 0));
        rst = 1'b1;
        #2;
        do_reset();

        // Directed vectors: RAW stall, unused source, flush, WAW, halt/resume.
        vecs.push_back(mk(1, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0008, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0008, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 1, 5, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1, 0, 16'h0020, 0, 0));
        vecs.push_back(mk(1, 1, 7, 3, 5, 1, 0, 0, 1, 0, 0, 0, 0, 16'h0020, 0, 0));
        vecs.push_back(idle(16'h0020, 0, 0));
        vecs.push_back(idle(16'h0000, 0, 0));
        vecs.push_back(mk(1, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0));
`ifdef HAZARD_SCOREBOARD_WAW_EN
        vecs.push_back(mk(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0004, 0, 0));
        vecs.push_back(mk(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0004, 0, 0));
        vecs.push_back(mk(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0004, 0, 0));
        vecs.push_back(mk(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0));
        vecs.push_back(idle(16'h0004, 0, 0));
        vecs.push_back(idle(16'h0000, 0, 0));
`else
        vecs.push_back(mk(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0004, 0, 0));
        vecs.push_back(idle(16'h0004, 0, 0));
        vecs.push_back(idle(16'h0000, 0, 0));
`endif
        vecs.push_back(mk(1, 1, 9, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0200, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0200, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0200, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0000, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0000, 1, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 0));
        vecs.push_back(idle(16'h0002, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            step($sformatf("vec%0d", i), 1'b1, vecs[i]);
        end

        // Asynchronous reset in the middle of DRAIN.
        t = mk(1, 1, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0, 0);
        drive(t);
        step("drn_wr", 1'b0, t);
        t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, '0, 0, 0);
        drive(t);
        step("drn_halt", 1'b0, t);
        t = idle('0, 0, 0);
        drive(t);
        step("drn_wait", 1'b0, t);
        chk("drn.pre_draining", 32'(draining),     32'(1));
        chk("drn.pre_busy4",    32'(busy_mask[4]), 32'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("drn_rst.busy",     32'(busy_mask), 32'(0));
        chk("drn_rst.halted",   32'(halted),    32'(0));
        chk("drn_rst.draining", 32'(draining),  32'(0));
        chk("drn_rst.state",    32'(state_dbg), 32'(0));
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        t = mk(1, 1, 6, 2, 4, 1, 0, 0, 0, 0, 0, 1, 0, '0, 0, 0);
        drive(t);
        step("post_rst", 1'b1, t);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            t.v   = ($urandom_range(0, 3) != 0);
            t.we  = $urandom_range(0, 1);
            t.dst = AW'($urandom_range(0, 5));
            t.lat = LW'($urandom_range(0, 3));
            t.s0  = AW'($urandom_range(0, 5));
            t.u0  = $urandom_range(0, 1);
            t.s1  = AW'($urandom_range(0, 5));
            t.u1  = $urandom_range(0, 1);
            t.fl  = ($urandom_range(0, 9) == 0);
            t.hr  = ($urandom_range(0, 39) == 0);
            t.rs  = ($urandom_range(0, 7) == 0);
            drive(t);
            step("rand", 1'b0, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised register scoreboard and issue controller for the pipelined datapath, sitting at the ID stage between the register file read and the ID/EX pipeline register. It tracks pending writes per architectural register with countdown counters, raises `stall` on read-after-write hazards that forwarding cannot cover, and sequences a halt through a drain phase so no write is lost. It generalises the fixed 16-register / fixed-latency hazard logic to any register count and per-instruction result latency.

## Interface
- `REG_ADDR_W`, 4, register address width; the scoreboard tracks 2^REG_ADDR_W registers.
- `LAT_W`, 2, counter width; the maximum issue latency is 2^LAT_W-1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-low.
- `issue_valid`  in  1  an instruction is presented at ID this cycle.
- `issue_we`  in  1  the presented instruction writes `issue_dst`.
- `issue_dst`  in  REG_ADDR_W  destination register.
- `issue_lat`  in  LAT_W  cycles until the result is forwardable; 0 means ready immediately.
- `src0_addr`, `src1_addr`  in  REG_ADDR_W  source registers.
- `src0_used`, `src1_used`  in  1  the corresponding source is actually read.
- `flush`  in  1  squash the presented instruction (branch taken).
- `halt_req`  in  1  one-cycle pulse requesting a halt.
- `resume`  in  1  one-cycle pulse leaving HALTED.
- `issue_accept`  out  1  the instruction is accepted into ID/EX this cycle.
- `stall`  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- `busy_mask`  out  2^REG_ADDR_W  bit r set when counter[r] != 0.
- `halted`  out  1  the FSM is in HALTED.
- `draining`  out  1  the FSM is in DRAIN.

## Operation
- State: counter[r] (LAT_W bits) for every register, plus FSM {RUN, DRAIN, HALTED}.
- hazard = (src0_used & counter[src0_addr]!=0) | (src1_used & counter[src1_addr]!=0), plus the WAW term when it is enabled (see Configuration). This uses the registered counters of the current cycle.
- stall = issue_valid & ~flush & (hazard | state!=RUN).
- issue_accept = issue_valid & ~flush & ~stall.
- Every clock, each nonzero counter decrements by 1; zero counters hold at 0 (no wrap).
- On issue_accept with issue_we, counter[issue_dst] loads issue_lat instead of decrementing. The load wins over the decrement.
- A flush with issue_valid gives accept=0 and stall=0, and the counters are not loaded.
- FSM transitions:
  - RUN: halt_req moves to DRAIN. If halt_req and issue_valid occur in the same cycle, the instruction is still evaluated under RUN rules, so it may be accepted.
  - DRAIN: when busy_mask==0 at the clock edge, move to HALTED. No issues are accepted.
  - HALTED: resume moves to RUN. halt_req is ignored.
  - resume in RUN or DRAIN is ignored.
- All registers are tracked equally; register 0 is not special.

## Timing
- Reset (async assert): all counters 0, state RUN. Outputs: issue_accept=0, stall=0, busy_mask=0, halted=0, draining=0. An accept is possible on the first edge after deassertion.
- stall, issue_accept and hazard are combinational from inputs and registered state, with zero-cycle latency.
- An instruction with issue_lat=L blocks dependent sources on the next L cycles. The dependent instruction issues L+1 cycles after the producer. For example, a load with L=2 gives one accept, two stall cycles, then accept.
- issue_lat=0 never blocks.
- DRAIN lasts max(counter) cycles, with a minimum of 1 cycle. halted asserts the cycle after the counters reach 0.
- Reset mid-DRAIN or mid-HALTED returns asynchronously to RUN with the counters cleared.

## Configuration
- `HAZARD_SCOREBOARD_WAW_EN` defined: hazard additionally includes issue_we & counter[issue_dst]!=0, so a second write to a pending register stalls until the first completes.
- Not defined: a write to a pending register is accepted, and counter[issue_dst] is overwritten with the new issue_lat, even if the new value is smaller.

## Test plan
- Reset then an accept at dst=3, lat=2. Next a source read of r3 -> stall=1 for 2 cycles, then accept; busy_mask[3] goes 1,1,0.
- A source using r5 with src0_used=0 while r5 is busy -> accept=1, stall=0.
- Flush with a hazard present -> accept=0 and stall=0; a later write to r7 from the flushed instruction does not set busy_mask[7].
- Back-to-back writes to r2 with lat=3 then lat=1:
  - with the macro: stall until counter[2]==0;
  - without the macro: the second instruction is accepted and busy_mask[2] clears after 1 cycle.
- halt_req with max counter 3 -> draining=1 for 3 cycles, then halted=1; issue_valid is stalled throughout; resume -> RUN and the next issue is accepted.
- Assert rst low during DRAIN -> immediately busy_mask=0, halted=0, draining=0.
